im2col_window_feeder: RTL
=========================

// Module: im2col_window_feeder
// PURPOSE
//  Parametrised im2col input feeder for the systolic array. It merges the padded and unpadded
//  feed paths into one FSM and adds kernel size, stride and zero-padding width as parameters/config.
//  It walks every output position of one input channel and reads the KxK window pixels from input SRAM.
//  Padded taps are zero-filled without an SRAM access. Each window is presented to the SA with a valid/ready handshake.
// PARAMETERS
//  ADR_W    16   SRAM word address width
//  SRAM_W   64   SRAM data width; LANES = SRAM_W/8 pixels per word
//  K        3    kernel side; window = K*K signed 8-bit taps
//  DIM_W    7    width of height/width/position counters (max dim 127)
//  MAX_PAD  2    largest supported padding
// PORTS
//  i_clk          in   1             clock, all logic on rising edge
//  i_rst          in   1             synchronous reset, active-high
//  i_start        in   1             pulse: latch cfg_* and begin a channel pass (honoured only in IDLE)
//  cfg_base_addr  in   ADR_W         word address of pixel (0,0) of current channel
//  cfg_height     in   DIM_W         input rows H (>=1)
//  cfg_width      in   DIM_W         input cols W (>=1)
//  cfg_pad        in   2             zero padding P (0..MAX_PAD)
//  cfg_stride     in   2             stride S (1..3; 0 treated as 1)
//  o_sram_addr    out  ADR_W         SRAM word address
//  o_sram_rden    out  1             SRAM read enable; data returns on i_sram_data next cycle
//  i_sram_data    in   SRAM_W        SRAM read data
//  o_win_valid    out  1             o_win holds a complete window
//  i_win_ready    in   1             SA accepts window (transfer = valid & ready)
//  o_win          out  8*K*K         taps, tap t = r*K+c at bits [8t+7:8t], signed
//  o_busy         out  1             high from accepted start until DONE
//  o_finished     out  1             one-cycle pulse after the last window transfers
// BEHAVIOUR
//  Reset: every output is 0, the FSM is in IDLE, and all counters and the tap buffer clear.
//    Reset mid-pass aborts immediately and raises no o_finished.
//  Geometry: OH = (H+2P-K)/S + 1 and OW = (W+2P-K)/S + 1, integer floor.
//    If H+2P<K or W+2P<K, there are zero windows: go directly to DONE.
//  Order: output rows oy = 0..OH-1; inside each row ox = 0..OW-1; inside each window taps t = 0..K*K-1 raster.
//  Tap coords: iy = oy*S + r - P, ix = ox*S + c - P (signed).
//    The tap is padded if iy<0, iy>=H, ix<0 or ix>=W.
//  Address: pix = iy*W + ix; o_sram_addr = base + pix/LANES; lane = pix%LANES.
//    The tap byte is i_sram_data[8*lane+:8]. Lane is registered alongside the read.
//  FSM:
//   IDLE  : wait for i_start. Latch cfg, clear counters, set o_busy -> FETCH.
//   FETCH : one tap per cycle. Assert o_sram_rden for real taps; padded taps write 0 into the buffer.
//           The buffer write of tap t-1 (from the SRAM response) happens in the same cycle as issue of tap t.
//           After issuing tap K*K-1 -> DRAIN.
//   DRAIN : capture the final SRAM response (or the pad 0) -> OUT.
//   OUT   : o_win_valid=1. o_win stays stable until the transfer.
//           On transfer, advance ox/oy -> FETCH, or -> DONE if it was the last window.
//           Valid never drops without a transfer.
//   DONE  : pulse o_finished for 1 cycle, clear o_busy -> IDLE.
//  Latency: start -> first o_win_valid = K*K+2 cycles. Back-to-back windows come every K*K+2 cycles when ready=1.
//  o_sram_rden is low outside FETCH and for padded taps; o_sram_addr holds its last value when rden is low.
//  i_start is ignored outside IDLE; cfg_* changes are ignored during a pass.
//  Buffer: the tap buffer is zeroed at each window start, so no stale data can leak.
//  Arithmetic: coords use DIM_W+2-bit signed intermediates; no wrap occurs for legal cfg.
//    Address add wraps modulo 2^ADR_W.
// TESTING
//  T1 no pad: K=3, H=W=4, P=0, S=1, pixel value=pix -> 4 windows.
//     Window 0 taps = 0,1,2,4,5,6,8,9,10; 9 rden per window; o_finished once.
//  T2 pad: H=W=3, P=1, S=1 -> 9 windows. Window 0 taps = 0,0,0,0,0,1,0,3,4.
//     Window 0 issues exactly 4 rden.
//  T3 stride: H=W=5, P=0, S=2 -> 4 windows at top-left (0,0),(0,2),(2,0),(2,2).
//     Last window taps = 12,13,14,17,18,19,22,23,24.
//  T4 backpressure: hold i_win_ready=0 for 20 cycles in OUT -> o_win stable, valid stays 1, no rden.
//     Release -> exactly one transfer.
//  T5 lanes/base: base=0x100, W=10, tap pix=13 -> addr 0x101 and lane 5 byte selected.
//     Also check i_start during a pass is ignored and H=W=2, P=0 gives immediate o_finished with zero windows.
//  T6 reset: assert i_rst during FETCH of window 2 -> next cycle all outputs 0 and FSM in IDLE.
//     A new i_start then restarts from window 0.

Source files
------------

// File: rtl/im2col_window_feeder.sv
// im2col_window_feeder: streams KxK im2col windows of one channel from input SRAM, zero-filling padded taps
module im2col_window_feeder #(
  parameter int ADR_W   = 16,
  parameter int SRAM_W  = 64,
  parameter int K       = 3,
  parameter int DIM_W   = 7,
  parameter int MAX_PAD = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADR_W-1:0]  cfg_base_addr,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [1:0]        cfg_pad,
  input  logic [1:0]        cfg_stride,
  output logic [ADR_W-1:0]  o_sram_addr,
  output logic              o_sram_rden,
  input  logic [SRAM_W-1:0] i_sram_data,
  output logic              o_win_valid,
  input  logic              i_win_ready,
  output logic [8*K*K-1:0]  o_win,
  output logic              o_busy,
  output logic              o_finished
);
  localparam int LB = $clog2(SRAM_W / 8);
  localparam int CW = DIM_W + 2;
  localparam int PW = 2 * DIM_W + 1;
  localparam int RW = $clog2(K + 1);
  localparam int TW = $clog2(K * K + 1);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DRAIN = 3'd2, OUT = 3'd3, DONE = 3'd4;
  logic [2:0] state_q, state_d;
  logic [ADR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [DIM_W-1:0] h_q, h_d, w_q, w_d;
  logic [1:0] pad_q, pad_d, str_q, str_d, pad_in;
  logic [CW-1:0] oy_q, oy_d, ox_q, ox_d, iy, ix, hp, wp;
  logic [RW-1:0] r_q, r_d, c_q, c_d;
  logic [TW-1:0] wt_q, wt_d;
  logic [LB-1:0] lane_q, lane_d;
  logic [K*K-1:0][7:0] win_q, win_d;
  logic wr_q, wr_d, wpad_q, wpad_d, tap_pad, col_last, last_tap, row_end, empty;
  logic [PW-1:0] pix;
  assign pad_in = cfg_pad > 2'(MAX_PAD) ? 2'(MAX_PAD) : cfg_pad;
  assign empty = CW'(cfg_height) + CW'({pad_in, 1'b0}) < CW'(K) || CW'(cfg_width) + CW'({pad_in, 1'b0}) < CW'(K);
  assign hp = CW'(h_q) + CW'({pad_q, 1'b0});
  assign wp = CW'(w_q) + CW'({pad_q, 1'b0});
  assign iy = oy_q + CW'(r_q) - CW'(pad_q);
  assign ix = ox_q + CW'(c_q) - CW'(pad_q);
  assign tap_pad = iy[CW-1] || ix[CW-1] || iy >= CW'(h_q) || ix >= CW'(w_q);
  assign pix = PW'(iy[DIM_W-1:0]) * PW'(w_q) + PW'(ix[DIM_W-1:0]);
  assign col_last = c_q == RW'(K - 1);
  assign last_tap = col_last && r_q == RW'(K - 1);
  assign row_end = ox_q + CW'(str_q) + CW'(K) > wp;
  assign o_sram_rden = state_q == FETCH && !tap_pad;
  assign addr_d = o_sram_rden ? base_q + ADR_W'(pix >> LB) : addr_q;
  assign o_sram_addr = addr_d;
  assign o_win_valid = state_q == OUT;
  assign o_win = win_q;
  assign o_busy = state_q != IDLE;
  assign o_finished = state_q == DONE;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    h_d = h_q;
    w_d = w_q;
    pad_d = pad_q;
    str_d = str_q;
    oy_d = oy_q;
    ox_d = ox_q;
    r_d = r_q;
    c_d = c_q;
    wr_d = state_q == FETCH;
    wpad_d = tap_pad;
    wt_d = TW'(r_q * K + c_q);
    lane_d = pix[LB-1:0];
    win_d = win_q;
    if (wr_q) win_d[wt_q] = wpad_q ? 8'd0 : i_sram_data[8*lane_q +: 8];
    case (state_q)
      IDLE: if (i_start) begin
        base_d = cfg_base_addr;
        h_d = cfg_height;
        w_d = cfg_width;
        pad_d = pad_in;
        str_d = cfg_stride == 2'd0 ? 2'd1 : cfg_stride;
        oy_d = '0;
        ox_d = '0;
        r_d = '0;
        c_d = '0;
        win_d = '0;
        state_d = empty ? DONE : FETCH;
      end
      FETCH: begin
        c_d = col_last ? '0 : c_q + RW'(1);
        r_d = last_tap ? '0 : col_last ? r_q + RW'(1) : r_q;
        state_d = last_tap ? DRAIN : FETCH;
      end
      DRAIN: state_d = OUT;
      OUT: if (i_win_ready) begin
        win_d = '0;
        ox_d = row_end ? '0 : ox_q + CW'(str_q);
        oy_d = row_end ? oy_q + CW'(str_q) : oy_q;
        state_d = row_end && oy_q + CW'(str_q) + CW'(K) > hp ? DONE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      base_q <= '0;
      addr_q <= '0;
      h_q <= '0;
      w_q <= '0;
      pad_q <= '0;
      str_q <= '0;
      oy_q <= '0;
      ox_q <= '0;
      r_q <= '0;
      c_q <= '0;
      wt_q <= '0;
      lane_q <= '0;
      win_q <= '0;
      wr_q <= 1'b0;
      wpad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      addr_q <= addr_d;
      h_q <= h_d;
      w_q <= w_d;
      pad_q <= pad_d;
      str_q <= str_d;
      oy_q <= oy_d;
      ox_q <= ox_d;
      r_q <= r_d;
      c_q <= c_d;
      wt_q <= wt_d;
      lane_q <= lane_d;
      win_q <= win_d;
      wr_q <= wr_d;
      wpad_q <= wpad_d;
    end
  end
endmodule
